// File: rtl/parity_arb_pkg.sv
// Shared types and default widths for the parity frame arbiter and its helpers.
package parity_arb_pkg;

  localparam int NUM_REQ_D = 4;
  localparam int DATA_W_D  = 8;
  localparam int CNT_W_D   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr,
// searching upward with wrap. N must be a power of two so the index wraps naturally.
module rr_pick #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit is the one that sticks.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + IW'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_frame_arbiter.sv
// Round-robin, frame-locked sharing of one XOR parity engine among NUM_REQ requesters;
// emits one registered {id, parity, count, overflow} record per frame.
module parity_frame_arbiter
  import parity_arb_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_D,
  parameter int  DATA_W  = DATA_W_D,
  parameter int  CNT_W   = CNT_W_D,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_parity,
  output logic [CNT_W-1:0]          res_count,
  output logic                      res_overflow
);

  arb_state_e state_q, state_d;

  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_parity_q, res_parity_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;
  logic              res_overflow_q, res_overflow_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] beat;
  logic              take;
  logic              acc_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              ovf_nxt;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    beat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == ID_W'(i)) beat = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    acc_d          = acc_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    res_id_d       = res_id_q;
    res_parity_d   = res_parity_q;
    res_count_d    = res_count_q;
    res_overflow_d = res_overflow_q;
    req_ready      = '0;
    res_valid      = 1'b0;
    take           = 1'b0;

    // Accumulator values as they would be after taking the current beat.
    acc_nxt   = acc_q ^ (^beat);
    count_nxt = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    ovf_nxt   = ovf_q | (count_q == '1);

    unique case (state_q)
      IDLE: begin
        acc_d   = 1'b0;
        count_d = '0;
        ovf_d   = 1'b0;
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[gnt_q] = 1'b1;
        take             = req_valid[gnt_q];
        if (take) begin
          acc_d   = acc_nxt;
          count_d = count_nxt;
          ovf_d   = ovf_nxt;
          if (req_last[gnt_q]) begin
            res_id_d       = gnt_q;
            res_parity_d   = acc_nxt;
            res_count_d    = count_nxt;
            res_overflow_d = ovf_nxt;
            state_d        = DONE;
          end
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          rr_ptr_d = gnt_q + ID_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      rr_ptr_q       <= '0;
      acc_q          <= 1'b0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      res_id_q       <= '0;
      res_parity_q   <= 1'b0;
      res_count_q    <= '0;
      res_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_ptr_q       <= rr_ptr_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      res_id_q       <= res_id_d;
      res_parity_q   <= res_parity_d;
      res_count_q    <= res_count_d;
      res_overflow_q <= res_overflow_d;
    end
  end

  assign res_id       = res_id_q;
  assign res_parity   = res_parity_q;
  assign res_count    = res_count_q;
  assign res_overflow = res_overflow_q;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Directed bench for parity_frame_arbiter; a second instance with a 4-bit counter
// shares the same stimulus so count saturation can be observed alongside the default width.
module tb_parity_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        res_ready;

  logic [3:0]  req_ready;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        res_parity;
  logic [7:0]  res_count;
  logic        res_overflow;

  logic [3:0]  req_ready4;
  logic        res_valid4;
  logic [1:0]  res_id4;
  logic        res_parity4;
  logic [3:0]  res_count4;
  logic        res_overflow4;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parity_frame_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(8)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
    .res_parity   (res_parity),
    .res_count    (res_count),
    .res_overflow (res_overflow)
  );

  parity_frame_arbiter #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready4),
    .res_valid    (res_valid4),
    .res_ready    (res_ready),
    .res_id       (res_id4),
    .res_parity   (res_parity4),
    .res_count    (res_count4),
    .res_overflow (res_overflow4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat and returns just after the edge on which it was accepted.
  task automatic apply_beat(input int ch, input logic [7:0] d, input logic last);
    bit taken;
    taken = 1'b0;
    req_valid[ch]        = 1'b1;
    req_data[ch*8 +: 8]  = d;
    req_last[ch]         = last;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[ch]) begin
        step();
        taken = 1'b1;
        break;
      end
      step();
    end
    check_output("beat_accept", 32'(taken), 32'd1);
    if (last) begin
      req_valid[ch] = 1'b0;
      req_last[ch]  = 1'b0;
    end
  endtask

  task automatic wait_res();
    for (int i = 0; i < 40; i++) begin
      if (res_valid) break;
      step();
    end
    check_output("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [1:0] id, input logic par,
                              input logic [7:0] cnt, input logic ovf);
    check_output({tag, "_id"},     32'(res_id),       32'(id));
    check_output({tag, "_parity"}, 32'(res_parity),   32'(par));
    check_output({tag, "_count"},  32'(res_count),    32'(cnt));
    check_output({tag, "_ovf"},    32'(res_overflow), 32'(ovf));
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    res_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check_output("reset_outputs",
                 32'({req_ready, res_valid, res_id, res_parity, res_count, res_overflow}), 32'd0);

    // Single frame from requester 2: 0x01,0x03,0x07 -> six ones, even parity.
    $display("[TB] single frame");
    t0 = cyc;
    apply_beat(2, 8'h01, 1'b0);
    apply_beat(2, 8'h03, 1'b0);
    apply_beat(2, 8'h07, 1'b1);
    check_output("single_res_valid", 32'(res_valid), 32'd1);
    check_output("single_latency", 32'(cyc - t0), 32'd4);
    check_output("single_ready_in_done", 32'(req_ready), 32'd0);
    check_result("single", 2'd2, 1'b0, 8'd3, 1'b0);
    handshake();
    check_output("single_after_hs", 32'({res_valid, req_ready}), 32'd0);

    // Fairness from a fresh pointer: all four stream 1-beat 0x80 frames.
    $display("[TB] round robin");
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h8080_8080;
    req_last  = 4'hF;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_res();
      check_result("rr", 2'(i % 4), 1'b1, 8'd1, 1'b0);
      step();
    end
    req_valid = '0;
    req_last  = '0;
    res_ready = 1'b0;
    step();

    // Backpressure: requester 1 frame 0x0F,0x10 (five ones), result held 10 cycles.
    $display("[TB] backpressure");
    apply_beat(1, 8'h0F, 1'b0);
    apply_beat(1, 8'h10, 1'b1);
    req_valid[3]      = 1'b1;
    req_data[31:24]   = 8'h01;
    req_last[3]       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_output("bp_hold",
                   32'({res_valid, req_ready, res_id, res_parity, res_count, res_overflow}),
                   32'({1'b1, 4'b0000, 2'd1, 1'b1, 8'd2, 1'b0}));
      step();
    end
    handshake();
    check_output("bp_released", 32'(res_valid), 32'd0);
    apply_beat(3, 8'h01, 1'b1);
    check_output("bp_next_valid", 32'(res_valid), 32'd1);
    check_result("bp_next", 2'd3, 1'b1, 8'd1, 1'b0);
    handshake();
    step();
    step();
    step();
    check_output("bp_single_result", 32'(res_valid), 32'd0);

    // Overflow: 20 beats of 0xFF; the 4-bit instance saturates at 15.
    $display("[TB] overflow");
    for (int i = 0; i < 20; i++) apply_beat(0, 8'hFF, (i == 19));
    check_result("ovf8", 2'd0, 1'b0, 8'd20, 1'b0);
    check_output("ovf4_valid",  32'(res_valid4),    32'd1);
    check_output("ovf4_count",  32'(res_count4),    32'd15);
    check_output("ovf4_ovf",    32'(res_overflow4), 32'd1);
    check_output("ovf4_parity", 32'(res_parity4),   32'd0);
    handshake();

    // Reset after two of five beats from requester 1.
    $display("[TB] reset mid-frame");
    apply_beat(1, 8'h11, 1'b0);
    apply_beat(1, 8'h22, 1'b0);
    req_data[15:8] = 8'h33;
    reset = 1'b1;
    step();
    check_output("midreset_outputs",
                 32'({req_ready, res_valid, res_id, res_parity, res_count, res_overflow}), 32'd0);
    check_output("midreset_outputs4",
                 32'({req_ready4, res_valid4, res_id4, res_parity4, res_count4, res_overflow4}),
                 32'd0);
    reset        = 1'b0;
    req_valid[1] = 1'b0;
    req_last     = '0;
    apply_beat(3, 8'h03, 1'b0);
    apply_beat(3, 8'hFE, 1'b1);
    check_result("fresh", 2'd3, 1'b1, 8'd2, 1'b0);
    handshake();

    // Gap: requester 2 idles mid-frame while requester 0 waits.
    $display("[TB] stall and gap");
    apply_beat(2, 8'hAA, 1'b0);
    req_valid[2]   = 1'b0;
    req_valid[0]   = 1'b1;
    req_data[7:0]  = 8'h01;
    req_last[0]    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("gap_grant_held", 32'(req_ready), 32'h4);
      step();
    end
    apply_beat(2, 8'h80, 1'b1);
    check_result("gap_frame", 2'd2, 1'b1, 8'd2, 1'b0);
    handshake();
    apply_beat(0, 8'h01, 1'b1);
    check_output("gap_waiter_valid", 32'(res_valid), 32'd1);
    check_result("gap_waiter", 2'd0, 1'b1, 8'd1, 1'b0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
